// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (hsync/vsync/blank/x/y) with registered outputs.
// Define VGA_TIMING_TEST_PATTERN_EN to drive colour bars on red/green/blue; otherwise they are 0.
module vga_timing_gen #(
  parameter int C_h_active = 640,
  parameter int C_h_fp = 16,
  parameter int C_h_sync = 96,
  parameter int C_h_bp = 48,
  parameter int C_v_active = 480,
  parameter int C_v_fp = 10,
  parameter int C_v_sync = 2,
  parameter int C_v_bp = 33,
  parameter logic C_hsync_pol = 1'b0,
  parameter logic C_vsync_pol = 1'b0,
  parameter int C_depth = 3
) (
  input logic clk_pixel,
  input logic reset,
  input logic ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic hsync,
  output logic vsync,
  output logic blank,
  output logic line_start,
  output logic frame_start,
  output logic [C_depth-1:0] red,
  output logic [C_depth-1:0] green,
  output logic [C_depth-1:0] blue
);
  localparam int H_TOTAL = C_h_active + C_h_fp + C_h_sync + C_h_bp;
  localparam int V_TOTAL = C_v_active + C_v_fp + C_v_sync + C_v_bp;
  logic [9:0] hcount, vcount;
  logic h_end, v_end, blank_d, hs_act, vs_act;
  always_comb begin
    h_end = hcount == 10'(H_TOTAL - 1);
    v_end = vcount == 10'(V_TOTAL - 1);
    blank_d = hcount >= 10'(C_h_active) || vcount >= 10'(C_v_active);
    hs_act = hcount >= 10'(C_h_active + C_h_fp) && hcount < 10'(C_h_active + C_h_fp + C_h_sync);
    vs_act = vcount >= 10'(C_v_active + C_v_fp) && vcount < 10'(C_v_active + C_v_fp + C_v_sync);
  end
  // outputs decode the pre-increment counters, giving one clock of latency
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
      x <= '0;
      y <= '0;
      blank <= 1'b1;
      hsync <= ~C_hsync_pol;
      vsync <= ~C_vsync_pol;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hcount <= h_end ? '0 : hcount + 10'd1;
      if (h_end) vcount <= v_end ? '0 : vcount + 10'd1;
      x <= hcount;
      y <= vcount;
      blank <= blank_d;
      hsync <= hs_act ? C_hsync_pol : ~C_hsync_pol;
      vsync <= vs_act ? C_vsync_pol : ~C_vsync_pol;
      line_start <= hcount == '0;
      frame_start <= hcount == '0 && vcount == '0;
    end
  end
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = hcount[8:6];
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      red <= '0;
      green <= '0;
      blue <= '0;
    end else if (ce) begin
      red <= blank_d ? '0 : {C_depth{bar[2]}};
      green <= blank_d ? '0 : {C_depth{bar[1]}};
      blue <= blank_d ? '0 : {C_depth{bar[0]}};
    end
  end
`else
  assign red = '0;
  assign green = '0;
  assign blue = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors plus a queued reference model for vga_timing_gen.
// Vertical timing is shortened so whole frames fit in a short run.
module tb_vga_timing_gen;
  localparam int HT = 800, VA = 24, VFP = 4, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
  logic clk_pixel = 1'b0, reset = 1'b1, ce = 1'b0;
  logic [9:0] x, y;
  logic hsync, vsync, blank, line_start, frame_start;
  logic [2:0] red, green, blue;
  vga_timing_gen #(.C_v_active(VA), .C_v_fp(VFP), .C_v_sync(VS), .C_v_bp(VBP)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .ce(ce), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .blank(blank), .line_start(line_start), .frame_start(frame_start),
    .red(red), .green(green), .blue(blue));
  always #5 clk_pixel = ~clk_pixel;
  typedef struct packed {
    logic [9:0] x, y;
    logic blank, hsync, vsync, ls, fs;
    logic [2:0] r, g, b;
  } out_t;
  typedef struct packed {
    logic r, c;
    out_t e;
  } vec_t;
  out_t q[$];
  out_t mexp;
  vec_t tbl[10];
  int n_cmp = 0, n_bad = 0, mh = 0, mv = 0;
  function automatic out_t mk(int px, int py, logic bl, logic hs, logic vs, logic ls, logic fs);
    out_t o;
    o = '0;
    o.x = 10'(px);
    o.y = 10'(py);
    o.blank = bl;
    o.hsync = hs;
    o.vsync = vs;
    o.ls = ls;
    o.fs = fs;
    return o;
  endfunction
  function automatic out_t decode(int h, int v);
    out_t o;
    logic [9:0] hv;
    logic [2:0] bar;
    hv = 10'(h);
    bar = hv[8:6];
    o = mk(h, v, h >= 640 || v >= VA, !(h >= 656 && h < 752), !(v >= VA + VFP && v < VA + VFP + VS),
           h == 0, h == 0 && v == 0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (!o.blank) begin
      o.r = {3{bar[2]}};
      o.g = {3{bar[1]}};
      o.b = {3{bar[0]}};
    end
`endif
    return o;
  endfunction
  function automatic out_t dut_out();
    out_t o;
    o.x = x; o.y = y; o.blank = blank; o.hsync = hsync; o.vsync = vsync;
    o.ls = line_start; o.fs = frame_start; o.r = red; o.g = green; o.b = blue;
    return o;
  endfunction
  task automatic cmp(string name, out_t act, out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b rgb=%o%o%o, expected x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b rgb=%o%o%o",
               name, act.x, act.y, act.blank, act.hsync, act.vsync, act.ls, act.fs, act.r, act.g, act.b,
               exp.x, exp.y, exp.blank, exp.hsync, exp.vsync, exp.ls, exp.fs, exp.r, exp.g, exp.b);
    end
  endtask
  task automatic cmp_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // drive one clock: the model's expectation is queued, the DUT output popped and checked after the edge
  task automatic cycle(logic r, logic c);
    out_t e;
    reset = r;
    ce = c;
    if (r) begin
      mexp = mk(0, 0, 1, 1, 1, 0, 0);
      mh = 0;
      mv = 0;
    end else if (c) begin
      mexp = decode(mh, mv);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh = mh + 1;
    end
    q.push_back(mexp);
    @(posedge clk_pixel);
    #1;
    e = q.pop_front();
    cmp("model", dut_out(), e);
  endtask
  task automatic run_to(int tx, int ty);
    int k;
    for (k = 0; k < 30000; k++) begin
      if (x == 10'(tx) && y == 10'(ty)) break;
      cycle(1'b0, 1'b1);
    end
    if (k == 30000) cmp_int("run_to timeout", int'(x), tx);
  endtask
  task automatic cmp_rgb(string name, logic [8:0] exp);
    n_cmp++;
    if ({red, green, blue} !== exp) begin
      n_bad++;
      $display("FAIL %s: got rgb=%o, expected rgb=%o", name, {red, green, blue}, exp);
    end
  endtask
  initial begin
    int hs_cnt, hs_first, vs_cnt, fs_cnt, vs_min;
    bit ls_y1;
    tbl[0] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 0, 0)};
    tbl[1] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 0, 0)};
    tbl[2] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 0, 0)};
    tbl[3] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 1)};
    tbl[4] = '{1'b0, 1'b1, mk(1, 0, 0, 1, 1, 0, 0)};
    tbl[5] = '{1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0, 0)};
    tbl[6] = '{1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0, 0)};
    tbl[7] = '{1'b0, 1'b1, mk(2, 0, 0, 1, 1, 0, 0)};
    tbl[8] = '{1'b1, 1'b0, mk(0, 0, 1, 1, 1, 0, 0)};
    tbl[9] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 1)};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].c);
      cmp($sformatf("vec%0d", i), dut_out(), tbl[i].e);
    end
    hs_cnt = 0; hs_first = -1; ls_y1 = 0;
    for (int i = 0; i < HT; i++) begin
      cycle(1'b0, 1'b1);
      if (!hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(x);
      end
      if (line_start && y == 10'd1 && x == 10'd0) ls_y1 = 1;
    end
    cmp_int("hsync width", hs_cnt, 96);
    cmp_int("hsync start", hs_first, 656);
    cmp_int("line_start y=1", int'(ls_y1), 1);
    vs_cnt = 0; fs_cnt = 0; vs_min = 1023;
    for (int i = 0; i < HT * VT; i++) begin
      cycle(1'b0, 1'b1);
      if (!vsync) begin
        vs_cnt++;
        if (int'(y) < vs_min) vs_min = int'(y);
      end
      if (frame_start) fs_cnt++;
    end
    cmp_int("vsync width", vs_cnt, 2 * HT);
    cmp_int("vsync first line", vs_min, VA + VFP);
    cmp_int("frame_start per frame", fs_cnt, 1);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    run_to(64, 1);
    cmp_rgb("rgb x=64", 9'o007);
    run_to(448, 1);
    cmp_rgb("rgb x=448", 9'o777);
`else
    run_to(64, 1);
    cmp_rgb("rgb x=64", 9'o000);
    run_to(448, 1);
    cmp_rgb("rgb x=448", 9'o000);
`endif
    run_to(700, 1);
    cmp_rgb("rgb x=700", 9'o000);
    run_to(300, 20);
    cycle(1'b1, 1'b1);
    cmp("mid-frame reset", dut_out(), mk(0, 0, 1, 1, 1, 0, 0));
    cycle(1'b0, 1'b1);
    cmp("after reset", dut_out(), mk(0, 0, 0, 1, 1, 1, 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
